// File: rtl/time_counter_pkg.sv
// Shared types and constants for the time-of-day counter.
package time_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int BCD_W   = 8;

    function automatic logic [BCD_W-1:0] toBcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter, 0..MODULUS-1, with a combinational wrap pulse for chaining.
module bcd_mod_counter
    import time_counter_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iClr,
    output logic [BCD_W-1:0] oCount,
    output logic             oWrap
);

    localparam logic [BCD_W-1:0] LAST = toBcd(MODULUS - 1);

    // Wrap is combinational so the next field advances on the same edge.
    assign oWrap = iEn & ~iClr & (oCount == LAST);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oCount <= '0;
        end else if (iClr) begin
            oCount <= '0;
        end else if (iEn) begin
            if (oCount == LAST)
                oCount <= '0;
            else if (oCount[3:0] == 4'd9)
                oCount <= {oCount[7:4] + 4'd1, 4'd0};
            else
                oCount <= {oCount[7:4], oCount[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/time_counter.sv
// Run/pause/set time-of-day counter driven by a divided tick; hh:mm:ss in BCD.
module time_counter
    import time_counter_pkg::*;
#(
    parameter int HOUR_MAX = 24
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iTick,
    input  logic             iStart,
    input  logic             iStop,
    input  logic             iClear,
    input  logic             iIncMin,
    input  logic             iIncHour,
    output logic [BCD_W-1:0] oSec,
    output logic [BCD_W-1:0] oMin,
    output logic [BCD_W-1:0] oHour,
    output logic             oRunning,
    output logic             oCarry
);

    state_t state;
    logic   tickQ;
    logic   secEvt, running, setMode;
    logic   secEn, minEn, hourEn;
    logic   secWrap, minWrap, hourWrap, dayWrap;

    assign secEvt  = iTick != tickQ;
    assign running = state == RUN;
    assign setMode = ~running;

    // Set-mode increments never ripple upward; only the run chain carries.
    assign secEn   = running & secEvt;
    assign minEn   = secWrap | (setMode & iIncMin);
    assign hourEn  = (secWrap & minWrap) | (setMode & iIncHour);
    assign dayWrap = secWrap & minWrap & hourWrap;

    bcd_mod_counter #(.MODULUS(SEC_MAX + 1)) uSec (
        .iClk(iClk), .iRst(iRst), .iEn(secEn), .iClr(iClear),
        .oCount(oSec), .oWrap(secWrap)
    );

    bcd_mod_counter #(.MODULUS(MIN_MAX + 1)) uMin (
        .iClk(iClk), .iRst(iRst), .iEn(minEn), .iClr(iClear),
        .oCount(oMin), .oWrap(minWrap)
    );

    bcd_mod_counter #(.MODULUS(HOUR_MAX)) uHour (
        .iClk(iClk), .iRst(iRst), .iEn(hourEn), .iClr(iClear),
        .oCount(oHour), .oWrap(hourWrap)
    );

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state    <= IDLE;
            tickQ    <= 1'b0;
            oRunning <= 1'b0;
            oCarry   <= 1'b0;
        end else begin
            tickQ  <= iTick;
            oCarry <= dayWrap;
            if (iClear) begin
                state    <= IDLE;
                oRunning <= 1'b0;
            end else begin
                case (state)
                    IDLE, PAUSE: if (iStart && !iStop) begin
                        state    <= RUN;
                        oRunning <= 1'b1;
                    end
                    RUN: if (iStop && !iStart) begin
                        state    <= PAUSE;
                        oRunning <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        oRunning <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Randomized + directed bench for time_counter, HOUR_MAX=24 and 12 side by side.
module tb_time_counter;

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic       iTick = 1'b0, iStart = 1'b0, iStop = 1'b0, iClear = 1'b0;
    logic       iIncMin = 1'b0, iIncHour = 1'b0;
    logic [7:0] oSec [2];
    logic [7:0] oMin [2];
    logic [7:0] oHour [2];
    logic       oRunning [2];
    logic       oCarry [2];

    int nChecks = 0, nErrors = 0;

    // Reference model: time as seconds-of-day, state as 0=idle 1=run 2=pause.
    int hmax [2] = '{24, 12};
    int mSec [2];
    int mState [2];
    int mCarry [2];
    int carryCnt [2];
    bit mTickQ;
    bit tickLvl;

    always #5 iClk = ~iClk;

    time_counter #(.HOUR_MAX(24)) dut24 (
        .iClk(iClk), .iRst(iRst), .iTick(iTick), .iStart(iStart), .iStop(iStop),
        .iClear(iClear), .iIncMin(iIncMin), .iIncHour(iIncHour),
        .oSec(oSec[0]), .oMin(oMin[0]), .oHour(oHour[0]),
        .oRunning(oRunning[0]), .oCarry(oCarry[0])
    );

    time_counter #(.HOUR_MAX(12)) dut12 (
        .iClk(iClk), .iRst(iRst), .iTick(iTick), .iStart(iStart), .iStop(iStop),
        .iClear(iClear), .iIncMin(iIncMin), .iIncHour(iIncHour),
        .oSec(oSec[1]), .oMin(oMin[1]), .oHour(oHour[1]),
        .oRunning(oRunning[1]), .oCarry(oCarry[1])
    );

    task automatic chk(input string tag, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mSec[k] = 0; mState[k] = 0; mCarry[k] = 0;
        end
        mTickQ = 1'b0;
    endtask

    task automatic modelStep();
        bit evt;
        int h, m, s;
        evt = (iTick != mTickQ);
        mTickQ = iTick;
        for (int k = 0; k < 2; k++) begin
            mCarry[k] = 0;
            if (iClear) begin
                mSec[k] = 0;
                mState[k] = 0;
            end else begin
                if (mState[k] == 1 && evt) begin
                    mSec[k] = (mSec[k] + 1) % (hmax[k] * 3600);
                    if (mSec[k] == 0) mCarry[k] = 1;
                end
                if (mState[k] != 1) begin
                    h = mSec[k] / 3600; m = (mSec[k] / 60) % 60; s = mSec[k] % 60;
                    if (iIncMin)  m = (m + 1) % 60;
                    if (iIncHour) h = (h + 1) % hmax[k];
                    mSec[k] = h * 3600 + m * 60 + s;
                end
                if (iStart && !iStop && mState[k] != 1) mState[k] = 1;
                else if (iStop && !iStart && mState[k] == 1) mState[k] = 2;
            end
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("sec%0d", hmax[k]), oSec[k], bcd(mSec[k] % 60));
            chk($sformatf("min%0d", hmax[k]), oMin[k], bcd((mSec[k] / 60) % 60));
            chk($sformatf("hour%0d", hmax[k]), oHour[k], bcd(mSec[k] / 3600));
            chk($sformatf("run%0d", hmax[k]), oRunning[k], (mState[k] == 1) ? 1 : 0);
            chk($sformatf("carry%0d", hmax[k]), oCarry[k], mCarry[k]);
            carryCnt[k] += oCarry[k];
        end
    endtask

    // One clock: drive inputs, model the edge, compare 1 time unit after.
    task automatic step(input bit st, input bit sp, input bit cl,
                        input bit im, input bit ih, input bit tg);
        if (tg) tickLvl = ~tickLvl;
        iTick = tickLvl; iStart = st; iStop = sp; iClear = cl;
        iIncMin = im; iIncHour = ih;
        @(posedge iClk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic toggles(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        modelReset();
        tickLvl = 1'b0;
        // Reset state
        repeat (2) @(negedge iClk);
        checkAll();
        iRst = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // Start and three seconds
        step(1, 0, 0, 0, 0, 0);
        toggles(3);
        chk("dirSec3", oSec[0], 8'h03);
        chk("dirRun", oRunning[0], 1);

        // Set 23:59:00 in pause, then roll the day over
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 23; i++) step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 59; i++) step(0, 0, 0, 1, 0, 0);
        chk("setHour24", oHour[0], 8'h23);
        chk("setHour12", oHour[1], 8'h11);
        chk("setMin", oMin[0], 8'h59);
        chk("setCarryNone", carryCnt[0] + carryCnt[1], 0);
        step(1, 0, 0, 0, 0, 0);
        toggles(60);
        chk("rollHour24", oHour[0], 8'h00);
        chk("rollHour12", oHour[1], 8'h00);
        chk("rollCarry24", carryCnt[0], 1);
        chk("rollCarry12", carryCnt[1], 1);

        // Tick coincident with stop still counts
        step(0, 1, 0, 0, 0, 1);
        chk("stopTick", oSec[0], 8'h01);
        chk("stopRun", oRunning[0], 0);
        toggles(3);
        chk("pauseHold", oSec[0], 8'h01);

        // Clear beats a coincident tick; start+stop in IDLE does nothing
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        toggles(9);
        chk("preClear", oSec[0], 8'h09);
        step(0, 0, 1, 0, 0, 1);
        chk("clrSec", oSec[0], 8'h00);
        chk("clrRun", oRunning[0], 0);
        step(1, 1, 0, 0, 0, 0);
        chk("startStopIdle", oRunning[0], 0);

        // Async reset mid-count at 12:34:56
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 34; i++) step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        toggles(56);
        chk("preRstHour", oHour[0], 8'h12);
        chk("preRstMin", oMin[0], 8'h34);
        chk("preRstSec", oSec[0], 8'h56);
        iStart = 1'b0;
        iRst = 1'b0;
        modelReset();
        #2;
        checkAll();
        tickLvl = 1'b1;
        iTick = 1'b1;
        repeat (2) @(negedge iClk);
        iRst = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        chk("postRstSec", oSec[0], 8'h00);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("postRstHold", oSec[0], 8'h00);
        step(0, 0, 0, 0, 0, 1);
        chk("postRstCount", oSec[0], 8'h01);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
